// File: rtl/sequence_pkg.sv
// Shared types and helpers for the sequence key checker: FSM encoding,
// key geometry and the cell-select function.
package sequence_pkg;
  localparam int CELL_W    = 4;
  localparam int NUM_CELLS = 4;
  localparam int KEY_W     = CELL_W * NUM_CELLS;
  localparam int IDX_W     = $clog2(NUM_CELLS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DIGIT = 2'd1,
    SOLVED     = 2'd2,
    FAILED     = 2'd3
  } state_t;

  // Cell 0 lives in the most significant nibble.
  function automatic logic [CELL_W-1:0] cell_sel(input logic [KEY_W-1:0] key,
                                                 input logic [IDX_W-1:0] idx);
    return key[(NUM_CELLS-1-int'(idx))*CELL_W +: CELL_W];
  endfunction
endpackage

// File: rtl/sequence_key_checker_if.sv
// Player/host-facing signal bundle of the sequence key checker.
interface sequence_key_checker_if;
  import sequence_pkg::*;
  logic [KEY_W-1:0]  sequence_key;
  logic              transmit;
  logic              enable;
  logic [CELL_W-1:0] digit;
  logic              digit_valid;
  logic              digit_ready;
  logic [IDX_W-1:0]  cell_index;
  logic              correct_pulse;
  logic              wrong_pulse;
  logic              timeout_pulse;
  logic [1:0]        strikes;
  logic              solved;
  logic              failed;

  modport slave (
    input  sequence_key, transmit, enable, digit, digit_valid,
    output digit_ready, cell_index, correct_pulse, wrong_pulse, timeout_pulse,
           strikes, solved, failed
  );

  modport master (
    output sequence_key, transmit, enable, digit, digit_valid,
    input  digit_ready, cell_index, correct_pulse, wrong_pulse, timeout_pulse,
           strikes, solved, failed
  );
endinterface

// File: rtl/sequence_key_checker_entry_timer.sv
// Per-digit entry timer: counts enabled cycles, flags the last allowed one,
// and wraps to zero on expiry so back-to-back timeouts are evenly spaced.
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign expired = count_en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_cnt <= '0;
    else if (clear || expired) r_cnt <= '0;
    else if (count_en)        r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/sequence_key_checker.sv
// Four-cell sequence key checker: the player enters digits one at a time,
// wrong digits and entry timeouts accumulate strikes until the round fails.
module sequence_key_checker
  import sequence_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_STRIKES    = 3
) (
  input logic              clk,
  input logic              rst,
  sequence_key_checker_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);
  localparam logic [1:0]       MAX_S    = 2'(MAX_STRIKES);

  state_t           r_state,   w_state;
  logic [KEY_W-1:0] r_key,     w_key;
  logic [IDX_W-1:0] r_idx,     w_idx;
  logic [1:0]       r_strikes, w_strikes;
  logic             r_correct, w_correct;
  logic             r_wrong,   w_wrong;
  logic             r_timeout, w_timeout;
  logic             r_solved,  w_solved;
  logic             r_failed,  w_failed;

  logic w_ready, w_accept, w_load, w_strike, w_expired, w_timer_clr;

  // Ready must follow enable in the same cycle for the handshake to be exact,
  // so it is decoded from the registered state rather than registered itself.
  assign w_ready     = (r_state == WAIT_DIGIT) && bus.enable;
  assign w_accept    = w_ready && bus.digit_valid;
  assign w_load      = bus.transmit && (r_state != FAILED);
  assign w_timer_clr = w_load || w_accept || (r_state != WAIT_DIGIT);

  entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_timer_clr),
    .count_en (w_ready),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_key     <= '0;
      r_idx     <= '0;
      r_strikes <= '0;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
      r_timeout <= 1'b0;
      r_solved  <= 1'b0;
      r_failed  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_key     <= w_key;
      r_idx     <= w_idx;
      r_strikes <= w_strikes;
      r_correct <= w_correct;
      r_wrong   <= w_wrong;
      r_timeout <= w_timeout;
      r_solved  <= w_solved;
      r_failed  <= w_failed;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_key     = r_key;
    w_idx     = r_idx;
    w_strikes = r_strikes;
    w_correct = 1'b0;
    w_wrong   = 1'b0;
    w_timeout = 1'b0;
    w_solved  = r_solved;
    w_failed  = r_failed;
    w_strike  = 1'b0;

    // A new key wins over any digit or expiry in the same cycle.
    if (w_load) begin
      w_state  = WAIT_DIGIT;
      w_key    = bus.sequence_key;
      w_idx    = '0;
      w_solved = 1'b0;
    end else if (r_state == WAIT_DIGIT) begin
      if (w_accept) begin
        if (bus.digit == cell_sel(r_key, r_idx)) begin
          w_correct = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_solved = 1'b1;
            w_state  = SOLVED;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end else begin
          w_wrong  = 1'b1;
          w_strike = 1'b1;
        end
      end else if (w_expired) begin
        w_timeout = 1'b1;
        w_wrong   = 1'b1;
        w_strike  = 1'b1;
      end

      if (w_strike) begin
        w_idx = '0;
        if (r_strikes != MAX_S) w_strikes = r_strikes + 1'b1;
        if (w_strikes == MAX_S) begin
          w_failed = 1'b1;
          w_state  = FAILED;
        end
      end
    end
  end

  assign bus.digit_ready   = w_ready;
  assign bus.cell_index    = r_idx;
  assign bus.correct_pulse = r_correct;
  assign bus.wrong_pulse   = r_wrong;
  assign bus.timeout_pulse = r_timeout;
  assign bus.strikes       = r_strikes;
  assign bus.solved        = r_solved;
  assign bus.failed        = r_failed;
endmodule

// File: tb/tb_sequence_key_checker.sv
// Bench for sequence_key_checker: directed vector table, hand-written corner
// sequences, and a randomized run against a digit-list reference model.
module tb_sequence_key_checker;
  import sequence_pkg::*;

  localparam int T  = 8;
  localparam int MS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequence_key_checker_if bus();

  sequence_key_checker #(.TIMEOUT_CYCLES(T), .MAX_STRIKES(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       c, w, t;
    logic [1:0] idx, stk;
    logic       sol, fl, rdy;
  } obs_t;

  typedef struct packed {
    logic        tx;
    logic [15:0] key;
    logic        dv;
    logic [3:0]  dig;
    obs_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: key held as a list of digits plus round bookkeeping.
  logic [3:0] m_key [4];
  int m_pos, m_stk, m_idle;
  bit m_active, m_solved, m_failed, m_c, m_w, m_t;

  function automatic obs_t mk(input logic c, w, t, input logic [1:0] idx, stk,
                              input logic sol, fl, rdy);
    obs_t o;
    o.c = c; o.w = w; o.t = t; o.idx = idx; o.stk = stk;
    o.sol = sol; o.fl = fl; o.rdy = rdy;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(bus.correct_pulse, bus.wrong_pulse, bus.timeout_pulse, bus.cell_index,
              bus.strikes, bus.solved, bus.failed, bus.digit_ready);
  endfunction

  function automatic obs_t model_obs(input logic en);
    return mk(m_c, m_w, m_t, 2'(m_pos), 2'(m_stk), m_solved, m_failed, m_active && en);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got c%b w%b t%b idx%0d stk%0d sol%b fl%b rdy%b, want c%b w%b t%b idx%0d stk%0d sol%b fl%b rdy%b",
               name, got.c, got.w, got.t, got.idx, got.stk, got.sol, got.fl, got.rdy,
               exp.c, exp.w, exp.t, exp.idx, exp.stk, exp.sol, exp.fl, exp.rdy);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_key[k] = 4'h0;
    m_pos = 0; m_stk = 0; m_idle = 0;
    m_active = 0; m_solved = 0; m_failed = 0; m_c = 0; m_w = 0; m_t = 0;
  endtask

  task automatic model_step(input logic tx, input logic [15:0] key, input logic en,
                            input logic dv, input logic [3:0] dig);
    bit miss;
    miss = 0;
    m_c = 0; m_w = 0; m_t = 0;
    if (tx && !m_failed) begin
      for (int k = 0; k < 4; k++) m_key[k] = key[15-4*k -: 4];
      m_active = 1; m_solved = 0; m_pos = 0; m_idle = 0;
    end else if (m_active) begin
      if (en && dv) begin
        m_idle = 0;
        if (dig == m_key[m_pos]) begin
          m_c = 1;
          if (m_pos == 3) begin m_solved = 1; m_active = 0; end
          else m_pos++;
        end else miss = 1;
      end else if (en) begin
        if (m_idle == T - 1) begin m_t = 1; m_idle = 0; miss = 1; end
        else m_idle++;
      end
      if (miss) begin
        m_w = 1; m_pos = 0;
        if (m_stk < MS) m_stk++;
        if (m_stk == MS) begin m_failed = 1; m_active = 0; end
      end
    end
  endtask

  // Drive one cycle: check the model before the edge, clock, advance the model.
  task automatic cyc(input logic tx, input logic [15:0] key, input logic en,
                     input logic dv, input logic [3:0] dig);
    bus.transmit = tx; bus.sequence_key = key; bus.enable = en;
    bus.digit_valid = dv; bus.digit = dig;
    #1;
    check("model", observe(), model_obs(en));
    @(posedge clk);
    model_step(tx, key, en, dv, dig);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("reset", observe(), '0);
    model_reset();
    bus.transmit = 0; bus.sequence_key = '0; bus.enable = 0;
    bus.digit_valid = 0; bus.digit = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vt [13];

  initial begin
    vt[0]  = '{1, 16'h3A5C, 0, 4'h0, mk(0,0,0,0,0,0,0,1)};
    vt[1]  = '{0, 16'h0000, 1, 4'h3, mk(1,0,0,1,0,0,0,1)};
    vt[2]  = '{0, 16'h0000, 1, 4'hA, mk(1,0,0,2,0,0,0,1)};
    vt[3]  = '{0, 16'h0000, 1, 4'h5, mk(1,0,0,3,0,0,0,1)};
    vt[4]  = '{0, 16'h0000, 1, 4'hC, mk(1,0,0,3,0,1,0,0)};
    vt[5]  = '{0, 16'h0000, 0, 4'h0, mk(0,0,0,3,0,1,0,0)};
    vt[6]  = '{1, 16'h3A5C, 0, 4'h0, mk(0,0,0,0,0,0,0,1)};
    vt[7]  = '{0, 16'h0000, 1, 4'h3, mk(1,0,0,1,0,0,0,1)};
    vt[8]  = '{0, 16'h0000, 1, 4'hA, mk(1,0,0,2,0,0,0,1)};
    vt[9]  = '{0, 16'h0000, 1, 4'h7, mk(0,1,0,0,1,0,0,1)};
    vt[10] = '{0, 16'h0000, 0, 4'h0, mk(0,0,0,0,1,0,0,1)};
    vt[11] = '{1, 16'h1234, 1, 4'h3, mk(0,0,0,0,1,0,0,1)};
    vt[12] = '{0, 16'h0000, 1, 4'h1, mk(1,0,0,1,1,0,0,1)};

    rst = 1'b1;
    do_reset();

    // Solve, wrong digit, and transmit-over-digit priority.
    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].tx, vt[i].key, 1'b1, vt[i].dv, vt[i].dig);
      check($sformatf("vec%0d", i), observe(), vt[i].exp);
    end

    // Timeout lands on the eighth cycle after transmit.
    do_reset();
    cyc(1, 16'h3A5C, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 16'h0, 1, 0, 0);
      check($sformatf("timeout_c%0d", i), observe(),
            (i == 8) ? mk(0,1,1,0,1,0,0,1) : mk(0,0,0,0,0,0,0,1));
    end
    // Enable low freezes the timer.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 16'h0, 0, 0, 0);
      check("enable_low", observe(), mk(0,0,0,0,1,0,0,0));
    end
    // A digit accepted on the expiry cycle beats the timeout.
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 16'h0, 1, 0, 0);
      check("pre_expiry", observe(), mk(0,0,0,0,1,0,0,1));
    end
    cyc(0, 16'h0, 1, 1, 4'h3);
    check("digit_vs_expiry", observe(), mk(1,0,0,1,1,0,0,1));

    // Three strikes fail the round; transmit and digits are then ignored.
    do_reset();
    cyc(1, 16'h3A5C, 1, 0, 0);
    cyc(0, 16'h0, 1, 1, 4'h0);
    check("strike1", observe(), mk(0,1,0,0,1,0,0,1));
    cyc(0, 16'h0, 1, 1, 4'h0);
    check("strike2", observe(), mk(0,1,0,0,2,0,0,1));
    cyc(0, 16'h0, 1, 1, 4'h0);
    check("strike3", observe(), mk(0,1,0,0,3,0,1,0));
    cyc(1, 16'h1111, 1, 0, 0);
    check("failed_tx", observe(), mk(0,0,0,0,3,0,1,0));
    cyc(0, 16'h0, 1, 1, 4'h3);
    check("failed_digit", observe(), mk(0,0,0,0,3,0,1,0));

    // Reset mid-round, then restart from cell 0.
    do_reset();
    cyc(1, 16'h3A5C, 1, 0, 0);
    cyc(0, 16'h0, 1, 1, 4'h3);
    cyc(0, 16'h0, 1, 1, 4'hA);
    check("two_correct", observe(), mk(1,0,0,2,0,0,0,1));
    do_reset();
    cyc(1, 16'h3A5C, 1, 0, 0);
    check("restart_tx", observe(), mk(0,0,0,0,0,0,0,1));
    cyc(0, 16'h0, 1, 1, 4'h3);
    check("restart_digit", observe(), mk(1,0,0,1,0,0,0,1));

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        logic tx, en, dv;
        logic [15:0] key;
        logic [3:0] dig;
        tx  = ($urandom_range(0, 15) == 0);
        key = 16'($urandom);
        en  = ($urandom_range(0, 7) != 0);
        dv  = 1'($urandom);
        dig = ($urandom_range(0, 1) == 1) ? m_key[m_pos] : 4'($urandom);
        cyc(tx, key, en, dv, dig);
      end
    end
    cyc(0, 16'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
